// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the IF stage of the 3-stage RV32 pipeline.
package pipe_pkg;
    typedef enum logic [2:0] {BOOT, REQ, HOLD, HALTED, ERROR} fetch_state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
        logic [31:0] inst;
    } fetch_bundle_t;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam fetch_bundle_t BUBBLE = '{pc: 32'h0, pc_plus_4: 32'h0, inst: NOP_INST};
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry parking slot for a fetch that arrived while ID was stalled.
module fetch_hold_buf import pipe_pkg::*; #(
    parameter fetch_bundle_t INIT = BUBBLE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clear,
    input  fetch_bundle_t din,
    output fetch_bundle_t dout,
    output logic          valid
);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dout  <= INIT;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (clear) begin
            dout  <= INIT;
            valid <= 1'b0;
        end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer; owns the PC, runs a single-outstanding imem handshake
// and drives the IF/ID D-inputs with stall, redirect, halt and timeout handling.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_id,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic [31:0] inst_out,
    output logic        halted,
    output logic        fetch_err
);
    import pipe_pkg::*;
    localparam int WW = $clog2(MAX_WAIT);
    localparam fetch_bundle_t NOP_BUNDLE = '{pc: 32'h0, pc_plus_4: 32'h0, inst: NOP_INST};
    fetch_state_e  state, state_n;
    logic          booted, squash, halt_pend, rv, halting, take, hold_valid;
    logic [31:0]   fpc, pend_pc, tgt;
    logic [WW-1:0] wait_cnt;
    fetch_bundle_t fetched, hold_q, last, bundle;
    assign rv        = state == REQ && imem_rvalid;
    assign halting   = halt_req || halt_pend;
    assign take      = rv && !squash && !redirect_valid && !halting;
    assign tgt       = {redirect_pc[31:2], 2'b00};
    assign imem_addr = fpc;
    assign fetched   = '{pc: fpc, pc_plus_4: fpc + 32'd4, inst: imem_rdata};
    assign bundle    = redirect_valid ? NOP_BUNDLE :
                       stall_id ? last :
                       (state == HOLD && hold_valid) ? hold_q :
                       take ? fetched : NOP_BUNDLE;
    assign pc_out        = bundle.pc;
    assign pc_plus_4_out = bundle.pc_plus_4;
    assign inst_out      = bundle.inst;
    fetch_hold_buf #(.INIT(NOP_BUNDLE)) u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (take && stall_id),
        .clear (state == HOLD && state_n != HOLD),
        .din   (fetched),
        .dout  (hold_q),
        .valid (hold_valid)
    );
    // Halt outranks redirect so a same-cycle EX redirect cannot un-halt the core.
    always_comb begin
        state_n = state;
        case (state)
            BOOT:    state_n = booted ? REQ : BOOT;
            REQ:     state_n = rv ? (halting ? HALTED : (take && stall_id) ? HOLD : REQ) :
                               (wait_cnt == WW'(MAX_WAIT - 1)) ? ERROR : REQ;
            HOLD:    state_n = halt_req ? HALTED : (redirect_valid || !stall_id) ? REQ : HOLD;
            HALTED:  state_n = (!halt_req && redirect_valid) ? REQ : HALTED;
            default: state_n = ERROR;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= BOOT;
            booted    <= 1'b0;
            imem_req  <= 1'b0;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
            fpc       <= RESET_PC;
            pend_pc   <= RESET_PC;
            squash    <= 1'b0;
            halt_pend <= 1'b0;
            wait_cnt  <= '0;
            last      <= NOP_BUNDLE;
        end else begin
            state     <= state_n;
            booted    <= 1'b1;
            imem_req  <= state_n == REQ;
            halted    <= state_n == HALTED;
            fetch_err <= state_n == ERROR;
            wait_cnt  <= (state == REQ && !imem_rvalid) ? wait_cnt + 1'b1 : '0;
            last      <= bundle;
            case (state)
                REQ:
                    if (rv) begin
                        squash    <= 1'b0;
                        halt_pend <= 1'b0;
                        if (redirect_valid) fpc <= tgt;
                        else if (squash) fpc <= pend_pc;
                        else if (take) fpc <= fpc + 32'd4;
                    end else begin
                        // Response still owed for the old address: drop it when it lands.
                        if (redirect_valid) begin
                            squash  <= 1'b1;
                            pend_pc <= tgt;
                        end
                        if (halt_req) halt_pend <= 1'b1;
                    end
                HOLD, HALTED:
                    if (state_n == REQ && redirect_valid) fpc <= tgt;
                default: ;
            endcase
        end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl (default and wrap-around RESET_PC).
module tb_fetch_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_rvalid = 1'b0, stall_id = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0;
    logic [31:0] imem_rdata = '0, redirect_pc = '0;
    logic        req_a, req_b, halted_a, halted_b, err_a, err_b;
    logic [31:0] addr_a, addr_b, pc_a, pc_b, pc4_a, pc4_b, inst_a, inst_b;
    logic [95:0] bun_a, bun_b;
    int          checks = 0, errors = 0;
    localparam logic [95:0] BUB = {64'h0, 32'h0000_0013};
    always #5 clk = ~clk;
    fetch_ctrl dut (
        .clk(clk), .rst(rst), .imem_req(req_a), .imem_addr(addr_a), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .stall_id(stall_id), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .pc_out(pc_a), .pc_plus_4_out(pc4_a),
        .inst_out(inst_a), .halted(halted_a), .fetch_err(err_a)
    );
    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .imem_req(req_b), .imem_addr(addr_b), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .stall_id(stall_id), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .pc_out(pc_b), .pc_plus_4_out(pc4_b),
        .inst_out(inst_b), .halted(halted_b), .fetch_err(err_b)
    );
    assign bun_a = {pc_a, pc4_a, inst_a};
    assign bun_b = {pc_b, pc4_b, inst_b};
    task automatic cyc(input logic rv, input logic [31:0] rd, input logic st,
                       input logic rdv, input logic [31:0] rp, input logic hr);
        @(negedge clk);
        imem_rvalid = rv; imem_rdata = rd; stall_id = st;
        redirect_valid = rdv; redirect_pc = rp; halt_req = hr;
        #1;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        checks++;
        if (req_a !== 1'b0 || halted_a !== 1'b0 || err_a !== 1'b0 || bun_a !== BUB) begin
            errors++;
            $display("FAIL reset req=%b halted=%b err=%b bundle=%h exp 0 0 0 %h", req_a, halted_a, err_a, bun_a, BUB);
        end
    endtask
    task automatic test_fetch;
        logic [95:0] e;
        @(negedge clk); rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        cyc(1, 32'h1111_1111, 0, 0, 0, 0);
        checks++;
        if (req_a !== 1'b0 || bun_a !== BUB) begin
            errors++; $display("FAIL boot req=%b bundle=%h exp 0 %h", req_a, bun_a, BUB);
        end
        cyc(1, 32'h0010_0093, 0, 0, 0, 0);
        e = {32'h0, 32'h4, 32'h0010_0093};
        checks++;
        if (req_a !== 1'b1 || addr_a !== 32'h0 || bun_a !== e) begin
            errors++; $display("FAIL fetch0 req=%b addr=%h bundle=%h exp 1 0 %h", req_a, addr_a, bun_a, e);
        end
        cyc(1, 32'h0020_0113, 0, 0, 0, 0);
        e = {32'h4, 32'h8, 32'h0020_0113};
        checks++;
        if (req_a !== 1'b1 || addr_a !== 32'h4 || bun_a !== e) begin
            errors++; $display("FAIL fetch4 req=%b addr=%h bundle=%h exp 1 4 %h", req_a, addr_a, bun_a, e);
        end
    endtask
    task automatic test_stall;
        logic [95:0] e;
        e = {32'h4, 32'h8, 32'h0020_0113};
        cyc(1, 32'h0050_0093, 1, 0, 0, 0);
        checks++;
        if (addr_a !== 32'h8 || bun_a !== e) begin
            errors++; $display("FAIL stall0 addr=%h bundle=%h exp 8 %h", addr_a, bun_a, e);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 1, 0, 0, 0);
            checks++;
            if (req_a !== 1'b0 || bun_a !== e) begin
                errors++; $display("FAIL stall_hold%0d req=%b bundle=%h exp 0 %h", i, req_a, bun_a, e);
            end
        end
        cyc(0, 0, 0, 0, 0, 0);
        e = {32'h8, 32'hC, 32'h0050_0093};
        checks++;
        if (bun_a !== e) begin
            errors++; $display("FAIL stall_release bundle=%h exp %h", bun_a, e);
        end
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (req_a !== 1'b1 || addr_a !== 32'hC || bun_a !== BUB) begin
            errors++; $display("FAIL stall_next req=%b addr=%h bundle=%h exp 1 c %h", req_a, addr_a, bun_a, BUB);
        end
    endtask
    task automatic test_redirect;
        logic [95:0] e;
        cyc(0, 0, 1, 1, 32'h0000_0103, 0);
        checks++;
        if (bun_a !== BUB) begin
            errors++; $display("FAIL redir_bubble bundle=%h exp %h", bun_a, BUB);
        end
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (req_a !== 1'b1 || addr_a !== 32'hC) begin
            errors++; $display("FAIL redir_hold req=%b addr=%h exp 1 c", req_a, addr_a);
        end
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        checks++;
        if (bun_a !== BUB) begin
            errors++; $display("FAIL redir_drop bundle=%h exp %h", bun_a, BUB);
        end
        cyc(1, 32'h0070_0193, 0, 0, 0, 0);
        e = {32'h100, 32'h104, 32'h0070_0193};
        checks++;
        if (req_a !== 1'b1 || addr_a !== 32'h100 || bun_a !== e) begin
            errors++; $display("FAIL redir_target req=%b addr=%h bundle=%h exp 1 100 %h", req_a, addr_a, bun_a, e);
        end
    endtask
    task automatic test_halt;
        logic [95:0] e;
        cyc(0, 0, 0, 0, 0, 1);
        checks++;
        if (addr_a !== 32'h104 || bun_a !== BUB) begin
            errors++; $display("FAIL halt_req addr=%h bundle=%h exp 104 %h", addr_a, bun_a, BUB);
        end
        cyc(1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        checks++;
        if (bun_a !== BUB) begin
            errors++; $display("FAIL halt_drop bundle=%h exp %h", bun_a, BUB);
        end
        cyc(0, 0, 0, 1, 32'h300, 1);
        checks++;
        if (halted_a !== 1'b1 || req_a !== 1'b0 || bun_a !== BUB) begin
            errors++; $display("FAIL halted halted=%b req=%b bundle=%h exp 1 0 %h", halted_a, req_a, bun_a, BUB);
        end
        cyc(0, 0, 0, 1, 32'h200, 0);
        checks++;
        if (halted_a !== 1'b1 || req_a !== 1'b0) begin
            errors++; $display("FAIL halt_priority halted=%b req=%b exp 1 0", halted_a, req_a);
        end
        cyc(1, 32'h0080_0213, 0, 0, 0, 0);
        e = {32'h200, 32'h204, 32'h0080_0213};
        checks++;
        if (halted_a !== 1'b0 || req_a !== 1'b1 || addr_a !== 32'h200 || bun_a !== e) begin
            errors++; $display("FAIL halt_resume halted=%b req=%b addr=%h bundle=%h exp 0 1 200 %h", halted_a, req_a, addr_a, bun_a, e);
        end
    endtask
    task automatic test_timeout;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            checks++;
            if (req_a !== 1'b1 || err_a !== 1'b0) begin
                errors++; $display("FAIL wait%0d req=%b err=%b exp 1 0", i, req_a, err_a);
            end
        end
        cyc(0, 0, 0, 0, 0, 0);
        checks++;
        if (err_a !== 1'b1 || req_a !== 1'b0 || bun_a !== BUB) begin
            errors++; $display("FAIL timeout err=%b req=%b bundle=%h exp 1 0 %h", err_a, req_a, bun_a, BUB);
        end
        cyc(1, 32'h0000_0093, 0, 1, 32'h40, 0);
        cyc(1, 32'h0000_0093, 0, 0, 0, 0);
        checks++;
        if (err_a !== 1'b1 || req_a !== 1'b0 || bun_a !== BUB) begin
            errors++; $display("FAIL error_sticky err=%b req=%b bundle=%h exp 1 0 %h", err_a, req_a, bun_a, BUB);
        end
        @(negedge clk); rst = 1'b1; imem_rvalid = 1'b0; #1;
        checks++;
        if (err_a !== 1'b0) begin
            errors++; $display("FAIL error_reset err=%b exp 0", err_a);
        end
    endtask
    task automatic test_wrap;
        logic [95:0] e;
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0090_0293;
        cyc(1, 32'h0090_0293, 0, 0, 0, 0);
        checks++;
        if (req_b !== 1'b0) begin
            errors++; $display("FAIL wrap_boot req=%b exp 0", req_b);
        end
        cyc(1, 32'h0090_0293, 0, 0, 0, 0);
        e = {32'hFFFF_FFFC, 32'h0, 32'h0090_0293};
        checks++;
        if (addr_b !== 32'hFFFF_FFFC || bun_b !== e) begin
            errors++; $display("FAIL wrap_first addr=%h bundle=%h exp fffffffc %h", addr_b, bun_b, e);
        end
        cyc(1, 32'h0090_0293, 0, 0, 0, 0);
        e = {32'h0, 32'h4, 32'h0090_0293};
        checks++;
        if (addr_b !== 32'h0 || bun_b !== e) begin
            errors++; $display("FAIL wrap_second addr=%h bundle=%h exp 0 %h", addr_b, bun_b, e);
        end
    endtask
    task automatic test_hold_redirect;
        logic [95:0] e;
        cyc(1, 32'h00A0_0313, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 32'h41, 0);
        checks++;
        if (req_a !== 1'b0 || bun_a !== BUB) begin
            errors++; $display("FAIL hold_redir req=%b bundle=%h exp 0 %h", req_a, bun_a, BUB);
        end
        cyc(1, 32'hDEAD_BEEF, 0, 1, 32'h83, 0);
        checks++;
        if (req_a !== 1'b1 || addr_a !== 32'h40 || bun_a !== BUB) begin
            errors++; $display("FAIL hold_target req=%b addr=%h bundle=%h exp 1 40 %h", req_a, addr_a, bun_a, BUB);
        end
        cyc(1, 32'h00B0_0393, 0, 0, 0, 0);
        e = {32'h80, 32'h84, 32'h00B0_0393};
        checks++;
        if (addr_a !== 32'h80 || bun_a !== e) begin
            errors++; $display("FAIL same_cycle_redir addr=%h bundle=%h exp 80 %h", addr_a, bun_a, e);
        end
    endtask
    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_halt();
        test_timeout();
        test_wrap();
        test_hold_redirect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
